// File: rtl/mvp_vertex_transformer_if.sv
// Handshake bundle between the MVP vertex transformer and its neighbours.
//   mvp_matrix [15:0][WI-1:0] row-major matrix, element (r,c) at index 4*r+c
//   in_vertex  [3:0][WI-1:0]  homogeneous input vertex, [0]=x [1]=y [2]=z [3]=w
//   in_valid / in_ready       input handshake
//   out_vertex [3:0][WO-1:0]  clip-space output vertex, same component order
//   out_valid / out_ready     output handshake
// master: the side that supplies vertices and consumes results (upstream/downstream).
// slave : the transformer itself.
interface mvp_vertex_transformer_if #(
  parameter int WII = 8,
  parameter int WIF = 8,
  parameter int WOI = 8,
  parameter int WOF = 8
);
  localparam int WI = WII + WIF;
  localparam int WO = WOI + WOF;

  logic [15:0][WI-1:0] mvp_matrix;
  logic [3:0][WI-1:0]  in_vertex;
  logic                in_valid;
  logic                in_ready;
  logic [3:0][WO-1:0]  out_vertex;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output mvp_matrix, in_vertex, in_valid, out_ready,
    input  in_ready, out_vertex, out_valid
  );

  modport slave (
    input  mvp_matrix, in_vertex, in_valid, out_ready,
    output in_ready, out_vertex, out_valid
  );
endinterface

// File: rtl/mvp_vertex_transformer.sv
// Applies a latched 4x4 MVP matrix to one homogeneous vertex, one matrix row per
// cycle on four signed multipliers, producing a fixed-point clip-space vertex.
// Ports:
//   Clk    rising-edge system clock
//   Reset  asynchronous, active-high reset; aborts any vertex in flight
//   bus    mvp_vertex_transformer_if.slave (matrix/vertex in, vertex out, valid/ready)
// Parameters: WII/WIF integer/fraction bits of inputs, WOI/WOF of outputs (0 <= WOF <= 2*WIF).
// Build option: define VT_SATURATE_EN to clamp each row result to the output range;
// otherwise results wrap to the low WOI+WOF bits.
// Timing: accept at edge T, rows 0..3 written at T+1..T+4, out_valid high after T+4.
module mvp_vertex_transformer #(
  parameter int WII = 8,
  parameter int WIF = 8,
  parameter int WOI = 8,
  parameter int WOF = 8
) (
  input logic                   Clk,
  input logic                   Reset,
  mvp_vertex_transformer_if.slave bus
);
  localparam int WI = WII + WIF;
  localparam int WO = WOI + WOF;
  localparam int PW = 2 * WI;
  localparam int SW = PW + 2;
  localparam int SH = 2 * WIF - WOF;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t              state;
  state_t              state_next;
  logic                in_ready;
  logic                out_valid;
  logic [15:0][WI-1:0] m_lat;
  logic [3:0][WI-1:0]  v_lat;
  logic [1:0]          row;
  logic [3:0][WO-1:0]  out_q;

  logic signed [PW-1:0] prod;
  logic signed [SW-1:0] acc;
  logic [WO-1:0]        row_res;
`ifdef VT_SATURATE_EN
  logic signed [SW-1:0] scaled;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_next = MAC;
      end
      MAC: begin
        if (row == 2'd3) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Current row dot product: full-width products, two guard bits, no truncation.
  always_comb begin
    prod = '0;
    acc  = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      prod = $signed(m_lat[{row, c[1:0]}]) * $signed(v_lat[c[1:0]]);
      acc  = acc + {{2{prod[PW-1]}}, prod};
    end
  end

  // Arithmetic shift floors toward -inf; the result is then clamped or wrapped.
`ifdef VT_SATURATE_EN
  always_comb begin
    scaled  = acc >>> SH;
    row_res = scaled[WO-1:0];
    if (scaled[SW-1:WO-1] != '0 && scaled[SW-1:WO-1] != '1) begin
      row_res = scaled[SW-1] ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}};
    end
  end
`else
  always_comb begin
    row_res = WO'(acc >>> SH);
  end
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_lat <= '0;
      v_lat <= '0;
      row   <= '0;
      out_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            m_lat <= bus.mvp_matrix;
            v_lat <= bus.in_vertex;
            row   <= '0;
          end
        end
        MAC: begin
          out_q[row] <= row_res;
          row        <= row + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_vertex = out_q;
endmodule

// File: tb/tb_mvp_vertex_transformer.sv
// Bench for mvp_vertex_transformer at WII=WIF=WOI=WOF=8 (1.0 = 16'h0100).
// Fixed vectors from a table, hand-written stall / matrix-change / reset sequences,
// then random vertices compared against a plain-arithmetic reference model.
module tb_mvp_vertex_transformer;
  typedef logic [15:0][15:0] mat_t;
  typedef logic [3:0][15:0]  vec_t;

  typedef struct {
    string name;
    mat_t  m;
    vec_t  v;
    vec_t  exp;
  } rec_t;

  logic Clk;
  logic Reset;
  int   n_cmp;
  int   n_err;

  mvp_vertex_transformer_if #(.WII(8), .WIF(8), .WOI(8), .WOF(8)) bus ();

  mvp_vertex_transformer #(.WII(8), .WIF(8), .WOI(8), .WOF(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact integer dot product, floor division by 2^8, then clamp or wrap.
  function automatic vec_t model(input mat_t m, input vec_t v);
    vec_t   r;
    longint s;
    longint q;
    for (int i = 0; i < 4; i++) begin
      s = 0;
      for (int j = 0; j < 4; j++)
        s += longint'($signed(m[4*i+j])) * longint'($signed(v[j]));
      q = s / 256;
      if (s < 0 && (s % 256) != 0) q = q - 1;
`ifdef VT_SATURATE_EN
      if (q > 32767) q = 32767;
      else if (q < -32768) q = -32768;
`endif
      r[i] = q[15:0];
    end
    return r;
  endfunction

  function automatic mat_t identity();
    mat_t m;
    m = '0;
    m[0]  = 16'h0100;
    m[5]  = 16'h0100;
    m[10] = 16'h0100;
    m[15] = 16'h0100;
    return m;
  endfunction

  function automatic vec_t mkvec(input logic [15:0] x, y, z, w);
    vec_t v;
    v[0] = x; v[1] = y; v[2] = z; v[3] = w;
    return v;
  endfunction

  // Full transaction: wait for in_ready, handshake, count edges to out_valid,
  // stall the output for 'stall' cycles, then complete the output handshake.
  task automatic do_vertex(input string name, input mat_t m, input vec_t v, input int stall,
                           input bit zero_after, output vec_t res, output int lat);
    int w;
    bit busy_bad;
    bus.mvp_matrix = m;
    bus.in_vertex  = v;
    bus.in_valid   = 1'b1;
    bus.out_ready  = 1'b0;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(posedge Clk); #1; w++;
    end
    check({name, "_ready_before_accept"}, 64'(bus.in_ready), 64'd1);
    @(posedge Clk); #1;
    bus.in_valid = 1'b0;
    if (zero_after) bus.mvp_matrix = '0;
    lat = 0;
    busy_bad = 1'b0;
    while (!bus.out_valid && lat < 20) begin
      if (bus.in_ready) busy_bad = 1'b1;
      @(posedge Clk); #1; lat++;
    end
    check({name, "_in_ready_low_busy"}, 64'(busy_bad), 64'd0);
    for (int s = 0; s < stall; s++) begin
      @(posedge Clk); #1;
    end
    res = bus.out_vertex;
    bus.out_ready = 1'b1;
    @(posedge Clk); #1;
    bus.out_ready = 1'b0;
    check({name, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
  endtask

  rec_t tbl[4];

  initial begin
    vec_t res;
    vec_t snap;
    vec_t v1;
    vec_t v2;
    int   lat;
    mat_t m;

    n_cmp = 0;
    n_err = 0;

    // Fixed vectors
    tbl[0].name = "identity";
    tbl[0].m    = identity();
    tbl[0].v    = mkvec(16'h0100, 16'h0200, 16'h0300, 16'h0100);
    tbl[0].exp  = mkvec(16'h0100, 16'h0200, 16'h0300, 16'h0100);

    m = '0;
    m[0] = 16'h0200; m[5] = 16'h0200; m[10] = 16'h0200; m[15] = 16'h0100; m[3] = 16'h0500;
    tbl[1].name = "diagonal";
    tbl[1].m    = m;
    tbl[1].v    = mkvec(16'h0100, 16'h0200, 16'h0300, 16'h0100);
    tbl[1].exp  = mkvec(16'h0700, 16'h0400, 16'h0600, 16'h0100);

    m = '0;
    m[0] = 16'h7F00;
    tbl[2].name = "overflow_pos";
    tbl[2].m    = m;
    tbl[2].v    = mkvec(16'h0200, 16'h0000, 16'h0000, 16'h0000);
    tbl[3].name = "overflow_neg";
    tbl[3].m    = m;
    tbl[3].v    = mkvec(16'hFE00, 16'h0000, 16'h0000, 16'h0000);
`ifdef VT_SATURATE_EN
    tbl[2].exp  = mkvec(16'h7FFF, 16'h0000, 16'h0000, 16'h0000);
    tbl[3].exp  = mkvec(16'h8000, 16'h0000, 16'h0000, 16'h0000);
`else
    tbl[2].exp  = mkvec(16'hFE00, 16'h0000, 16'h0000, 16'h0000);
    tbl[3].exp  = mkvec(16'h0200, 16'h0000, 16'h0000, 16'h0000);
`endif

    // Reset state
    Reset          = 1'b1;
    bus.mvp_matrix = '0;
    bus.in_vertex  = '0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_in_ready",   64'(bus.in_ready),  64'd1);
    check("reset_out_valid",  64'(bus.out_valid), 64'd0);
    check("reset_out_vertex", bus.out_vertex,     64'd0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    foreach (tbl[i]) begin
      do_vertex(tbl[i].name, tbl[i].m, tbl[i].v, 0, 1'b0, res, lat);
      check({tbl[i].name, "_result"},  res, tbl[i].exp);
      check({tbl[i].name, "_latency"}, 64'(lat), 64'd4);
    end

    // Output stall for 10 cycles with a second vertex already waiting
    v1 = mkvec(16'h0100, 16'h0200, 16'h0300, 16'h0100);
    v2 = mkvec(16'h0010, 16'h0020, 16'h0030, 16'h0040);
    bus.mvp_matrix = identity();
    bus.in_vertex  = v1;
    bus.in_valid   = 1'b1;
    bus.out_ready  = 1'b0;
    lat = 0;
    while (!bus.in_ready && lat < 20) begin
      @(posedge Clk); #1; lat++;
    end
    @(posedge Clk); #1;
    bus.in_vertex = v2;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge Clk); #1; lat++;
    end
    check("stall_latency", 64'(lat), 64'd4);
    snap = bus.out_vertex;
    check("stall_result", snap, v1);
    for (int k = 0; k < 10; k++) begin
      @(posedge Clk); #1;
      check("stall_valid_held",  64'(bus.out_valid), 64'd1);
      check("stall_vertex_held", bus.out_vertex,     snap);
      check("stall_in_ready",    64'(bus.in_ready),  64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge Clk); #1;
    bus.out_ready = 1'b0;
    check("stall_release_valid", 64'(bus.out_valid), 64'd0);
    check("stall_release_ready", 64'(bus.in_ready),  64'd1);
    @(posedge Clk); #1;
    bus.in_valid = 1'b0;
    check("second_accepted", 64'(bus.in_ready), 64'd0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge Clk); #1; lat++;
    end
    check("second_latency", 64'(lat), 64'd4);
    check("second_result",  bus.out_vertex, v2);
    bus.out_ready = 1'b1;
    @(posedge Clk); #1;
    bus.out_ready = 1'b0;

    // Matrix changes after acceptance must not disturb the vertex in flight
    do_vertex("matrix_change", identity(), v1, 1, 1'b1, res, lat);
    check("matrix_change_result", res, v1);

    // Reset in MAC after row 1 has been written
    bus.mvp_matrix = identity();
    bus.in_vertex  = v1;
    bus.in_valid   = 1'b1;
    lat = 0;
    while (!bus.in_ready && lat < 20) begin
      @(posedge Clk); #1; lat++;
    end
    @(posedge Clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin
      @(posedge Clk); #1;
    end
    Reset = 1'b1;
    #1;
    check("abort_out_valid",  64'(bus.out_valid), 64'd0);
    check("abort_in_ready",   64'(bus.in_ready),  64'd1);
    check("abort_out_vertex", bus.out_vertex,     64'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    do_vertex("after_abort", tbl[1].m, tbl[1].v, 0, 1'b0, res, lat);
    check("after_abort_result",  res, tbl[1].exp);
    check("after_abort_latency", 64'(lat), 64'd4);

    // Random vertices against the reference model
    for (int n = 0; n < 40; n++) begin
      mat_t rm;
      vec_t rv;
      for (int e = 0; e < 16; e++) rm[e] = 16'($urandom);
      for (int e = 0; e < 4; e++)  rv[e] = 16'($urandom);
      if (n < 10) begin
        // Small magnitudes keep results inside the output range.
        for (int e = 0; e < 16; e++) rm[e] = 16'($signed(rm[e]) >>> 6);
        for (int e = 0; e < 4; e++)  rv[e] = 16'($signed(rv[e]) >>> 6);
      end
      do_vertex("random", rm, rv, int'($urandom_range(0, 3)), 1'b0, res, lat);
      check("random_result",  res, model(rm, rv));
      check("random_latency", 64'(lat), 64'd4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
